regfft_seq: RTL and testbench

Frame sequencer for the 64 x 38-bit FFT register memory (`regffti`). It accepts a stream of 64 input words and writes them into the memory in natural order. It then reads the frame back in bit-reversed order (or natural order, set by parameter) and presents it as a 64-beat output burst to the FFT datapath. It is the only master of the memory's `regfft_wren`, `regfft_addr` and `data_in` pins.

---
 rtl/regfft_seq.sv | 159 +++++++++++++++
 tb/tb_regfft_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfft_seq.sv
// regfft_seq: frame sequencer for the 64-word FFT register memory.
// Writes one frame of input words in natural order, then reads it back in
// bit-reversed (or natural) order as an uninterrupted output burst.
module regfft_seq #(
    parameter int DW     = 38,
    parameter int AW     = 6,
    parameter int BITREV = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          drain_en,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic [7:0]    frames_done,
    output logic          regfft_wren,
    output logic [AW-1:0] regfft_addr,
    output logic [DW-1:0] regfft_din,
    input  logic [DW-1:0] regfft_dout
);

    localparam logic [1:0]    S_FILL  = 2'd0;
    localparam logic [1:0]    S_FULL  = 2'd1;
    localparam logic [1:0]    S_DRAIN = 2'd2;
    localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    // Read-address mapping: bit-reversal of the output position, or identity.
    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        r = k;
        if (BITREV != 0) begin
            for (int i = 0; i < AW; i++) begin
                r[i] = k[AW-1-i];
            end
        end else begin
            r = k;
        end
        return r;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [7:0]    frames_done_q, frames_done_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_index_q, out_index_d;
    logic          out_last_q, out_last_d;
    logic          accept_s;

    // State and counter registers with synchronous reset; memory is untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FILL;
            wcnt_q        <= {AW{1'b0}};
            rcnt_q        <= {AW{1'b0}};
            frames_done_q <= 8'd0;
            out_valid_q   <= 1'b0;
            out_index_q   <= {AW{1'b0}};
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            frames_done_q <= frames_done_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            out_last_q    <= out_last_d;
        end
    end

    // Next-state, counter advance and read-side alignment (one cycle behind the read issue).
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        rcnt_d        = rcnt_q;
        frames_done_d = frames_done_q;
        out_valid_d   = 1'b0;
        out_index_d   = out_index_q;
        out_last_d    = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept_s) begin
                    wcnt_d = wcnt_q + CNT_ONE;
                    if (wcnt_q == CNT_MAX) begin
                        state_d = S_FULL;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            S_FULL: begin
                if (drain_en) begin
                    state_d = S_DRAIN;
                    rcnt_d  = {AW{1'b0}};
                end else begin
                    state_d = S_FULL;
                end
            end
            S_DRAIN: begin
                rcnt_d      = rcnt_q + CNT_ONE;
                out_valid_d = 1'b1;
                out_index_d = rcnt_q;
                if (rcnt_q == CNT_MAX) begin
                    out_last_d    = 1'b1;
                    state_d       = S_FILL;
                    frames_done_d = frames_done_q + 8'd1;
                end else begin
                    out_last_d = 1'b0;
                end
            end
            default: begin
                state_d = S_FILL;
                wcnt_d  = {AW{1'b0}};
                rcnt_d  = {AW{1'b0}};
            end
        endcase
    end

    // Memory-side outputs; reset forces handshake and write enable low immediately.
    always_comb begin
        in_ready    = 1'b0;
        regfft_addr = {AW{1'b0}};
        regfft_din  = in_data;
        case (state_q)
            S_FILL: begin
                in_ready    = ~reset;
                regfft_addr = wcnt_q;
            end
            S_FULL: begin
                in_ready    = 1'b0;
                regfft_addr = {AW{1'b0}};
            end
            S_DRAIN: begin
                in_ready    = 1'b0;
                regfft_addr = map_addr(rcnt_q);
            end
            default: begin
                in_ready    = 1'b0;
                regfft_addr = {AW{1'b0}};
            end
        endcase
        accept_s    = in_valid & in_ready;
        regfft_wren = accept_s;
    end

    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign out_last    = out_last_q;
    assign frames_done = frames_done_q;
    assign out_data    = regfft_dout;

endmodule

// File: tb/tb_regfft_seq.sv
// Testbench for regfft_seq: a bit-reversed instance (a) and a natural-order
// instance (b) share stimulus, each backed by its own memory model.
module tb_regfft_seq;
    localparam int DW = 38;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic drain_en = 1'b0;

    logic in_ready_a, out_valid_a, out_last_a, wren_a;
    logic [DW-1:0] out_data_a, din_a, dout_a;
    logic [AW-1:0] out_index_a, addr_a;
    logic [7:0] frames_done_a;
    logic in_ready_b, out_valid_b, out_last_b, wren_b;
    logic [DW-1:0] out_data_b, din_b, dout_b;
    logic [AW-1:0] out_index_b, addr_b;
    logic [7:0] frames_done_b;

    logic [DW-1:0] mem_a [64];
    logic [DW-1:0] mem_b [64];

    int checks = 0;
    int failures = 0;
    logic [DW+AW:0] qa[$];
    logic [DW+AW:0] qb[$];

    always #5 clk = ~clk;

    regfft_seq #(.DW(DW), .AW(AW), .BITREV(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .drain_en(drain_en), .out_valid(out_valid_a),
        .out_data(out_data_a), .out_index(out_index_a), .out_last(out_last_a),
        .frames_done(frames_done_a), .regfft_wren(wren_a), .regfft_addr(addr_a),
        .regfft_din(din_a), .regfft_dout(dout_a));

    regfft_seq #(.DW(DW), .AW(AW), .BITREV(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .drain_en(drain_en), .out_valid(out_valid_b),
        .out_data(out_data_b), .out_index(out_index_b), .out_last(out_last_b),
        .frames_done(frames_done_b), .regfft_wren(wren_b), .regfft_addr(addr_b),
        .regfft_din(din_b), .regfft_dout(dout_b));

    // Single-port memory models: a write leaves data_out unchanged.
    always @(posedge clk) begin
        if (wren_a) mem_a[addr_a] <= din_a;
        else        dout_a <= mem_a[addr_a];
        if (wren_b) mem_b[addr_b] <= din_b;
        else        dout_b <= mem_b[addr_b];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic bit reversal of a 6-bit position.
    function automatic int rev6(input int k);
        int r = 0;
        for (int i = 0; i < 6; i++) r = r * 2 + ((k >> i) & 1);
        return r;
    endfunction

    // Scoreboard monitor, instance a.
    always @(negedge clk) begin
        logic [DW+AW:0] e;
        if (out_valid_a) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected actual=valid index=%0d required=idle", out_index_a);
            end else begin
                e = qa.pop_front();
                chk("a_data", 64'(out_data_a), 64'(e[DW-1:0]));
                chk("a_index", 64'(out_index_a), 64'(e[DW+AW-1:DW]));
                chk("a_last", 64'(out_last_a), 64'(e[DW+AW]));
            end
        end
    end

    // Scoreboard monitor, instance b.
    always @(negedge clk) begin
        logic [DW+AW:0] e;
        if (out_valid_b) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected actual=valid index=%0d required=idle", out_index_b);
            end else begin
                e = qb.pop_front();
                chk("b_data", 64'(out_data_b), 64'(e[DW-1:0]));
                chk("b_index", 64'(out_index_b), 64'(e[DW+AW-1:DW]));
                chk("b_last", 64'(out_last_b), 64'(e[DW+AW]));
            end
        end
    end

    // Feed one frame of words base+n; checks each write and queues the readout.
    task automatic fill(input int base, input bit gap, input bit b2b);
        int n = 0;
        int cyc = 0;
        bit tog = 1'b1;
        bit acc;
        logic [AW-1:0] k6;
        while (n < 64 && cyc < 400) begin
            in_valid = gap ? tog : 1'b1;
            in_data  = DW'(base + n);
            tog = ~tog;
            @(negedge clk);
            acc = in_valid && in_ready_a;
            chk("wren_a", 64'(wren_a), 64'(acc));
            chk("wren_b", 64'(wren_b), 64'(acc));
            if (acc) begin
                chk("waddr_a", 64'(addr_a), 64'(n));
                chk("waddr_b", 64'(addr_b), 64'(n));
                chk("wdata", 64'(din_a), 64'(base + n));
                if (b2b && n == 0) chk("b2b_first_write_with_last", 64'(out_last_a), 64'd1);
            end
            @(posedge clk); #1;
            if (acc) n++;
            cyc++;
        end
        chk("fill_accepts", 64'(n), 64'd64);
        for (int k = 0; k < 64; k++) begin
            k6 = AW'(k);
            qa.push_back({(k == 63), k6, DW'(base + rev6(k))});
            qb.push_back({(k == 63), k6, DW'(base + k)});
        end
    endtask

    task automatic wait_drained(input int fd);
        int c = 0;
        while ((qa.size() != 0 || qb.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("drain_complete", 64'(qa.size() + qb.size()), 64'd0);
        @(posedge clk); #1;
        chk("frames_done_a", 64'(frames_done_a), 64'(fd));
        chk("frames_done_b", 64'(frames_done_b), 64'(fd));
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; drain_en = 1'b0;
        qa.delete(); qb.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready_a), 64'd0);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_last", 64'(out_last_a), 64'd0);
        chk("rst_out_index", 64'(out_index_a), 64'd0);
        chk("rst_frames_done", 64'(frames_done_a), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready_a), 64'd1);
    endtask

    initial begin
        int c;
        // 1 & 2: bit-reversed and natural readout of words n
        do_reset();
        drain_en = 1'b1;
        fill(0, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_drained(1);

        // 3: gapped input, words 100+n
        fill(100, 1'b1, 1'b0);
        in_valid = 1'b0;
        wait_drained(2);

        // 4: held in FULL while in_valid presses an all-ones word
        drain_en = 1'b0;
        fill(400, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 38'h3FFFFFFFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("full_in_ready", 64'(in_ready_a), 64'd0);
            chk("full_wren", 64'(wren_a | wren_b), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        c = 0;
        while (c < 10) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (out_valid_a) break;
        end
        chk("drain_latency", 64'(c), 64'd2);
        wait_drained(3);

        // 5: back-to-back frames with in_valid and drain_en held high
        do_reset();
        drain_en = 1'b1;
        fill(300, 1'b0, 1'b0);
        fill(200, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_drained(2);

        // 6: reset at k = 10 of a drain, then a fresh frame
        fill(700, 1'b0, 1'b0);
        in_valid = 1'b0;
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (out_valid_a && out_index_a == AW'(10)) break;
        end
        chk("reached_k10", 64'(out_index_a), 64'd10);
        #1;
        reset = 1'b1;
        drain_en = 1'b0;
        @(posedge clk); #1;
        qa.delete(); qb.delete();
        chk("rst_forced_in_ready", 64'(in_ready_a), 64'd0);
        @(negedge clk);
        chk("midrst_out_valid_a", 64'(out_valid_a), 64'd0);
        chk("midrst_out_valid_b", 64'(out_valid_b), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready_a), 64'd1);
        chk("midrst_frames_done", 64'(frames_done_a), 64'd0);
        drain_en = 1'b1;
        fill(800, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_drained(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
